// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation sequencer: FSM state encoding,
// the width of the seconds-remaining counter and the watering mode encodings.
package irrigation_pkg;

  // 13 bits holds 5999 s (99:59), the largest duration the display can show.
  localparam int unsigned REM_W = 13;

  localparam logic MODE_SPR  = 1'b0;
  localparam logic MODE_DRIP = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StIrrigate,
    StDrain,
    StFault
  } state_e;

  // The selected valve is open while settling and while watering.
  function automatic logic valve_open(state_e s);
    return (s == StSettle) || (s == StIrrigate);
  endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Signal bundle between the irrigation sequencer and its surroundings.
//   slave  : sequencer side (sensors/request in, valves/stopwatch/status out)
//   master : controller/board side (drives sensors/request, observes outputs)
// Signals:
//   start, mode, soil_dry, water_low          request and sensor inputs
//   sec_tick, crono_en, crono_clr             one-second tick and stopwatch control
//   valve_spr, valve_drip, busy, alarm        valve drives and status
//   remaining                                 seconds left in the current timed state
interface irrigation_sequencer_if;
  import irrigation_pkg::*;

  logic             start;
  logic             mode;
  logic             soil_dry;
  logic             water_low;
  logic             sec_tick;
  logic             crono_en;
  logic             crono_clr;
  logic             valve_spr;
  logic             valve_drip;
  logic             busy;
  logic             alarm;
  logic [REM_W-1:0] remaining;

  modport slave (
    input  start, mode, soil_dry, water_low,
    output sec_tick, crono_en, crono_clr, valve_spr, valve_drip, busy, alarm, remaining
  );

  modport master (
    output start, mode, soil_dry, water_low,
    input  sec_tick, crono_en, crono_clr, valve_spr, valve_drip, busy, alarm, remaining
  );

endinterface

// File: rtl/sec_prescaler.sv
// Free-running divide-by-CLK_HZ prescaler.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   restart    : reload the counter to 0 on the next edge
//   tick       : high during the last count of each CLK_HZ-cycle period; it is a
//                decode of the counter register, so the consumer acts on the
//                same edge at which the period ends
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/irrigation_sequencer.sv
// Watering-cycle sequencer: settle, irrigate, drain, with a low-water fault
// path. Derives the one-second tick and drives the stopwatch enable/clear.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   irr        : irrigation_sequencer_if.slave (request, sensors, valves,
//                stopwatch control, status and seconds remaining)
// All outputs come straight from registers.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SETTLE_S   = 2,
  parameter int unsigned SPRINKLE_S = 600,
  parameter int unsigned DRIP_S     = 1800,
  parameter int unsigned DRAIN_S    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irrigation_sequencer_if.slave irr
);

  localparam logic [REM_W-1:0] SETTLE_LD   = REM_W'(SETTLE_S);
  localparam logic [REM_W-1:0] SPRINKLE_LD = REM_W'(SPRINKLE_S);
  localparam logic [REM_W-1:0] DRIP_LD     = REM_W'(DRIP_S);
  localparam logic [REM_W-1:0] DRAIN_LD    = REM_W'(DRAIN_S);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             start_q;
  logic             start_rise;
  logic             accept;
  logic             tick;
  logic             rem_last;
  logic             open_d;

  logic sec_tick_q, crono_en_q, crono_clr_q;
  logic valve_spr_q, valve_drip_q, busy_q, alarm_q;

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .tick   (tick)
  );

  assign start_rise = irr.start & ~start_q;
  // Exit on the tick that would take the count from 1 to 0 (0 guards a zero load).
  assign rem_last   = (rem_q <= REM_W'(1));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        rem_d = '0;
        if (start_rise) begin
          if (irr.water_low) begin
            state_d = StFault;
          end else if (irr.soil_dry) begin
            state_d = StSettle;
            mode_d  = irr.mode;
            rem_d   = SETTLE_LD;
            accept  = 1'b1;
          end
        end
      end
      StSettle: begin
        // Low water wins over a tick landing in the same cycle.
        if (irr.water_low) begin
          state_d = StFault;
          rem_d   = '0;
        end else if (tick) begin
          if (rem_last) begin
            state_d = StIrrigate;
            rem_d   = (mode_q == MODE_DRIP) ? DRIP_LD : SPRINKLE_LD;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      StIrrigate: begin
        if (irr.water_low) begin
          state_d = StFault;
          rem_d   = '0;
        end else if (tick) begin
          if (rem_last) begin
            state_d = StDrain;
            rem_d   = DRAIN_LD;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      StDrain: begin
        if (tick) begin
          if (rem_last) begin
            state_d = StIdle;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      StFault: begin
        rem_d = '0;
        if (start_rise && !irr.water_low) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
      end
    endcase
  end

  assign open_d = valve_open(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      mode_q       <= MODE_SPR;
      start_q      <= 1'b0;
      sec_tick_q   <= 1'b0;
      crono_en_q   <= 1'b0;
      crono_clr_q  <= 1'b0;
      valve_spr_q  <= 1'b0;
      valve_drip_q <= 1'b0;
      busy_q       <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      start_q      <= irr.start;
      // A prescaler restart swallows a tick that would coincide with it.
      sec_tick_q   <= tick & ~accept;
      crono_en_q   <= tick & ~accept & (state_d == StIrrigate);
      crono_clr_q  <= accept;
      valve_spr_q  <= open_d & (mode_d == MODE_SPR);
      valve_drip_q <= open_d & (mode_d == MODE_DRIP);
      busy_q       <= (state_d != StIdle) && (state_d != StFault);
      alarm_q      <= (state_d == StFault);
    end
  end

  assign irr.sec_tick   = sec_tick_q;
  assign irr.crono_en   = crono_en_q;
  assign irr.crono_clr  = crono_clr_q;
  assign irr.valve_spr  = valve_spr_q;
  assign irr.valve_drip = valve_drip_q;
  assign irr.busy       = busy_q;
  assign irr.alarm      = alarm_q;
  assign irr.remaining  = rem_q;

endmodule

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Control stage directly upstream of the stopwatch/display path. It derives a one-second tick from the board clock and runs the watering-cycle state machine: settle, irrigate, drain, with a fault path for low tank water. It also drives the stopwatch's count-enable and clear, so the display shows elapsed watering time.

## Interface
- `CLK_HZ`, default 50_000_000: board clock cycles per second; the prescaler terminal count.
- `SETTLE_S`, default 2: seconds the valve stays open before timed watering begins.
- `SPRINKLE_S`, default 600: watering duration in sprinkler mode.
- `DRIP_S`, default 1800: watering duration in drip mode.
- `DRAIN_S`, default 3: seconds after valve close before the cycle completes.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous assert, active-low reset.
- `start` input 1: synchronised, debounced request level; only its rising edge acts.
- `mode` input 1: 0 = sprinkler, 1 = drip; sampled at cycle start.
- `soil_dry` input 1: moisture sensor; 1 = watering is needed.
- `water_low` input 1: tank level sensor; 1 = insufficient water.
- `sec_tick` output 1: one-cycle pulse, once per second; free-running except in the cases listed under Timing.
- `crono_en` output 1: stopwatch count enable; equals `sec_tick` while in IRRIGATE.
- `crono_clr` output 1: one-cycle stopwatch clear, issued on cycle accept.
- `valve_spr`, `valve_drip` output 1 each: valve drives; never both high.
- `busy` output 1: high in any state other than IDLE and FAULT.
- `alarm` output 1: high in FAULT.
- `remaining` output 13: seconds left in the current timed state; 0 in IDLE and FAULT.

## Operation
- States: IDLE, SETTLE, IRRIGATE, DRAIN, FAULT.
- Start edge detection:
  - `start_q` is `start` registered once.
  - `start_rise` = `start` & ~`start_q`.
- IDLE:
  - `start_rise` & `water_low` → FAULT.
  - Else `start_rise` & `soil_dry` → SETTLE. On this transition:
    - latch `mode`;
    - load `remaining` = `SETTLE_S`;
    - pulse `crono_clr`;
    - restart the prescaler.
  - `start_rise` & ~`soil_dry` → stay in IDLE; no outputs change.
- SETTLE: the selected valve is open. When `remaining` hits 0, go to IRRIGATE and load `SPRINKLE_S` or `DRIP_S` per the latched mode.
- IRRIGATE: the valve stays open and `crono_en` is active. When `remaining` hits 0, go to DRAIN, load `DRAIN_S`, and close the valves.
- DRAIN: valves closed. When `remaining` hits 0 → IDLE.
- `remaining` decrements by 1 on each `sec_tick`. A state exits on the tick that would take it from 1 to 0. Width is 13 bits, so the maximum load is 5999 (99:59).
- Low water: `water_low` = 1 in SETTLE or IRRIGATE → FAULT on the next edge. This has priority over the tick-driven transition in the same cycle.
- `water_low` in DRAIN is ignored.
- FAULT: valves closed, `alarm` = 1. A `start_rise` with `water_low` = 0 → IDLE and clears `alarm`. A `start_rise` while `water_low` = 1 stays in FAULT.
- Asserting `rst_n` mid-cycle closes the valves immediately (asynchronously) and returns to IDLE.

## Timing
- Reset values:
  - `sec_tick`, `crono_en`, `crono_clr`, `valve_spr`, `valve_drip`, `busy`, `alarm` = 0.
  - `remaining` = 0; state = IDLE; prescaler = 0.
- First `sec_tick` comes `CLK_HZ` cycles after `rst_n` deasserts. Ticks then follow every `CLK_HZ` cycles.
- On cycle accept, the prescaler reloads. The first tick in SETTLE falls exactly `CLK_HZ` cycles after the accept edge.
- Latencies from the accepting edge (`start_rise` registered):
  - `crono_clr`, `busy`, and the valve output go high on the same edge, i.e. 1 cycle after `start` rises.
  - Total open-valve time = (`SETTLE_S` + duration) × `CLK_HZ` cycles, exact.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `crono_en` pulses line up cycle-for-cycle with `sec_tick`.

## Structure
- Shared package `irrigation_pkg`:
  - state enum;
  - `REM_W` = 13;
  - mode encodings `MODE_SPR` and `MODE_DRIP`.
- Sub-module `sec_prescaler`:
  - ports: `clk`, `rst_n`, `restart`, `tick`;
  - parameter: `CLK_HZ`;
  - counter width is `$clog2(CLK_HZ)`.
- The top level holds the FSM, the `remaining` counter, and output registers.

## Test plan
Benches run with `CLK_HZ`=10, `SETTLE_S`=2, `SPRINKLE_S`=5, `DRIP_S`=7, `DRAIN_S`=3.
- Sprinkler cycle. Stimulus: `soil_dry`=1, `mode`=0, `start` pulse. Required:
  - `crono_clr` pulses once;
  - `valve_spr` is high for exactly 70 cycles;
  - `crono_en` gives 5 pulses;
  - `busy` falls 30 cycles after the valve closes.
- Drip cycle: same as the sprinkler cycle with `mode`=1. Required: `valve_drip` high for 90 cycles, `valve_spr` never high.
- Start with `soil_dry`=0. Required: state stays IDLE, all outputs 0, `sec_tick` keeps its period of 10.
- `water_low` rises on the same cycle as the last IRRIGATE tick. Required:
  - FAULT is entered and `alarm` = 1;
  - valves go to 0 on the next edge;
  - DRAIN is not entered.
- FAULT recovery:
  - `start` with `water_low`=1 → remains in FAULT;
  - then `water_low`=0 and `start` → IDLE, `alarm`=0.
- `rst_n` pulsed low during IRRIGATE with `remaining`=3. Required: valves and `busy` drop without waiting for a clock edge, and `remaining` reads 0.
